// File: rtl/raster_tile_sched.sv
// -----------------------------------------------------------------------------
// raster_tile_sched
//
// Front-end scheduler for the rasterizer. Accepts one packed fp16 triangle at
// a time, launches the bounding-box unit, waits for the integer screen-space
// bounds and then walks every pixel of the box in row-major order towards the
// edge-function stage. Only one triangle is in flight at any time.
//
// Optional feature (compile-time macro RASTER_SCHED_WDT_EN):
//   When defined, a watchdog counts cycles spent in WAIT_BBOX. If no
//   bbox_valid shows up within WDT_CYCLES cycles the triangle is aborted with
//   a one-cycle tri_err pulse. When undefined, no counter is built, tri_err
//   is tied low and WAIT_BBOX waits indefinitely.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   tri_valid/tri_ready       upstream triangle handshake
//   tri_data   [TRI_W]        packed triangle (3 vertices x 3 fp16 fields)
//   bbox_start                one-cycle launch pulse to the bbox unit
//   bbox_tri   [TRI_W]        triangle held stable to the bbox unit
//   bbox_valid                bbox result strobe (only honoured in WAIT_BBOX)
//   bbox_{x,y}_{min,max}      clamped integer bounds
//   px_valid/px_ready         downstream pixel handshake
//   px_x, px_y [COORD_W]      pixel coordinate
//   px_last                   current pixel is the final one of the triangle
//   tri_done                  one-cycle pulse, triangle fully scheduled
//   tri_err                   one-cycle pulse, triangle aborted by watchdog
// -----------------------------------------------------------------------------
module raster_tile_sched #(
  parameter int TRI_W      = 144,
  parameter int COORD_W    = 8,
  parameter int WDT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tri_valid,
  output logic               tri_ready,
  input  logic [TRI_W-1:0]   tri_data,
  output logic               bbox_start,
  output logic [TRI_W-1:0]   bbox_tri,
  input  logic               bbox_valid,
  input  logic [COORD_W-1:0] bbox_x_min,
  input  logic [COORD_W-1:0] bbox_x_max,
  input  logic [COORD_W-1:0] bbox_y_min,
  input  logic [COORD_W-1:0] bbox_y_max,
  output logic               px_valid,
  input  logic               px_ready,
  output logic [COORD_W-1:0] px_x,
  output logic [COORD_W-1:0] px_y,
  output logic               px_last,
  output logic               tri_done,
  output logic               tri_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BBOX,
    S_SCAN,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [TRI_W-1:0]   tri_q, tri_d;
  logic [COORD_W-1:0] x_min_q, x_min_d;
  logic [COORD_W-1:0] x_max_q, x_max_d;
  logic [COORD_W-1:0] y_min_q, y_min_d;
  logic [COORD_W-1:0] y_max_q, y_max_d;
  logic [COORD_W-1:0] px_x_q, px_x_d;
  logic [COORD_W-1:0] px_y_q, px_y_d;
  logic               px_last_q, px_last_d;

  // Incremented coordinates kept at COORD_W so that the equality tests below
  // never see a widened value; the walk stops on equality before the
  // increment could wrap past 255.
  logic [COORD_W-1:0] px_x_inc, px_y_inc;
  assign px_x_inc = px_x_q + 1'b1;
  assign px_y_inc = px_y_q + 1'b1;

`ifdef RASTER_SCHED_WDT_EN
  localparam int CntW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(WDT_CYCLES - 1);
  logic [CntW-1:0] wdt_cnt_q, wdt_cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    tri_d     = tri_q;
    x_min_d   = x_min_q;
    x_max_d   = x_max_q;
    y_min_d   = y_min_q;
    y_max_d   = y_max_q;
    px_x_d    = px_x_q;
    px_y_d    = px_y_q;
    px_last_d = px_last_q;
`ifdef RASTER_SCHED_WDT_EN
    wdt_cnt_d = wdt_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (tri_valid) begin
          tri_d   = tri_data;
          state_d = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
`ifdef RASTER_SCHED_WDT_EN
        wdt_cnt_d = '0;
`endif
        state_d = S_WAIT_BBOX;
      end

      S_WAIT_BBOX: begin
        if (bbox_valid) begin
          x_min_d = bbox_x_min;
          x_max_d = bbox_x_max;
          y_min_d = bbox_y_min;
          y_max_d = bbox_y_max;
          if ((bbox_x_min > bbox_x_max) || (bbox_y_min > bbox_y_max)) begin
            // Empty or offscreen box: retire without issuing any pixel.
            state_d = S_DONE;
          end else begin
            px_x_d    = bbox_x_min;
            px_y_d    = bbox_y_min;
            px_last_d = (bbox_x_min == bbox_x_max) && (bbox_y_min == bbox_y_max);
            state_d   = S_SCAN;
          end
        end
`ifdef RASTER_SCHED_WDT_EN
        else if (wdt_cnt_q == CntMax) begin
          state_d = S_ERR;
        end else begin
          wdt_cnt_d = wdt_cnt_q + 1'b1;
        end
`endif
      end

      S_SCAN: begin
        if (px_ready) begin
          if ((px_x_q == x_max_q) && (px_y_q == y_max_q)) begin
            state_d = S_DONE;
          end else if (px_x_q == x_max_q) begin
            px_x_d    = x_min_q;
            px_y_d    = px_y_inc;
            px_last_d = (x_min_q == x_max_q) && (px_y_inc == y_max_q);
          end else begin
            px_x_d    = px_x_inc;
            px_last_d = (px_x_inc == x_max_q) && (px_y_q == y_max_q);
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tri_q     <= '0;
      x_min_q   <= '0;
      x_max_q   <= '0;
      y_min_q   <= '0;
      y_max_q   <= '0;
      px_x_q    <= '0;
      px_y_q    <= '0;
      px_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tri_q     <= tri_d;
      x_min_q   <= x_min_d;
      x_max_q   <= x_max_d;
      y_min_q   <= y_min_d;
      y_max_q   <= y_max_d;
      px_x_q    <= px_x_d;
      px_y_q    <= px_y_d;
      px_last_q <= px_last_d;
    end
  end

`ifdef RASTER_SCHED_WDT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt_q <= '0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
    end
  end
  assign tri_err = (state_q == S_ERR);
`else
  assign tri_err = 1'b0;
`endif

  // All control outputs are decoded from the registered state, so each pulse
  // lasts exactly one cycle and nothing combinational reaches the ports.
  assign tri_ready  = (state_q == S_IDLE);
  assign bbox_start = (state_q == S_LAUNCH);
  assign px_valid   = (state_q == S_SCAN);
  assign tri_done   = (state_q == S_DONE);
  assign bbox_tri   = tri_q;
  assign px_x       = px_x_q;
  assign px_y       = px_y_q;
  assign px_last    = px_last_q;

endmodule

// File: tb/tb_raster_tile_sched.sv
module tb_raster_tile_sched;

  localparam int TRI_W   = 144;
  localparam int COORD_W = 8;

  logic               clk;
  logic               rst;
  logic               tri_valid;
  logic               tri_ready;
  logic [TRI_W-1:0]   tri_data;
  logic               bbox_start;
  logic [TRI_W-1:0]   bbox_tri;
  logic               bbox_valid;
  logic [COORD_W-1:0] bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max;
  logic               px_valid;
  logic               px_ready;
  logic [COORD_W-1:0] px_x, px_y;
  logic               px_last;
  logic               tri_done;
  logic               tri_err;

  raster_tile_sched #(.TRI_W(TRI_W), .COORD_W(COORD_W), .WDT_CYCLES(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .tri_valid  (tri_valid),
    .tri_ready  (tri_ready),
    .tri_data   (tri_data),
    .bbox_start (bbox_start),
    .bbox_tri   (bbox_tri),
    .bbox_valid (bbox_valid),
    .bbox_x_min (bbox_x_min),
    .bbox_x_max (bbox_x_max),
    .bbox_y_min (bbox_y_min),
    .bbox_y_max (bbox_y_max),
    .px_valid   (px_valid),
    .px_ready   (px_ready),
    .px_x       (px_x),
    .px_y       (px_y),
    .px_last    (px_last),
    .tri_done   (tri_done),
    .tri_err    (tri_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected pixels {last, x, y} and expected retire pulses.
  logic [16:0] exp_q[$];
  int          exp_done = 0;
  int          exp_err  = 0;

  task automatic chk(input string name, input logic [TRI_W-1:0] act,
                     input logic [TRI_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every pixel handshake and every pulse against the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (px_valid && px_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel", {px_last, px_x, px_y}, 17'h1ffff);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          chk("pixel", {px_last, px_x, px_y}, e);
          $display("pixel x=%0d y=%0d last=%0d (exp x=%0d y=%0d last=%0d)",
                   px_x, px_y, px_last, e[15:8], e[7:0], e[16]);
        end
      end
      if (tri_done) begin
        chk("done_expected", (exp_done > 0), 1'b1);
        if (exp_done > 0) exp_done--;
        $display("tri_done pulse");
      end
      if (tri_err) begin
        chk("err_expected", (exp_err > 0), 1'b1);
        if (exp_err > 0) exp_err--;
        $display("tri_err pulse");
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_tri(input logic [TRI_W-1:0] td);
    int n;
    n = 0;
    while (!tri_ready && n < 50) begin
      step();
      n++;
    end
    chk("tri_ready_wait", tri_ready, 1'b1);
    tri_valid = 1'b1;
    tri_data  = td;
    step();
    tri_valid = 1'b0;
    chk("bbox_start_pulse", bbox_start, 1'b1);
    chk("bbox_tri_latched", bbox_tri, td);
    chk("tri_ready_busy", tri_ready, 1'b0);
    step();
    chk("bbox_start_one_cycle", bbox_start, 1'b0);
  endtask

  task automatic give_bbox(input int x0, input int x1, input int y0, input int y1);
    if (x0 <= x1 && y0 <= y1) begin
      for (int y = y0; y <= y1; y++)
        for (int x = x0; x <= x1; x++)
          exp_q.push_back({(x == x1 && y == y1) ? 1'b1 : 1'b0, 8'(x), 8'(y)});
    end
    exp_done++;
    bbox_valid = 1'b1;
    bbox_x_min = 8'(x0);
    bbox_x_max = 8'(x1);
    bbox_y_min = 8'(y0);
    bbox_y_max = 8'(y1);
    step();
    bbox_valid = 1'b0;
    bbox_x_min = 8'h00;
    bbox_x_max = 8'hff;
    bbox_y_min = 8'h00;
    bbox_y_max = 8'hff;
    $display("bbox x=%0d..%0d y=%0d..%0d issued", x0, x1, y0, y1);
  endtask

  // Counts cycles until tri_done is visible; bounded.
  task automatic wait_done(output int c);
    c = 0;
    while (!tri_done && c < 1000) begin
      step();
      c++;
    end
    chk("done_within_bound", tri_done, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    logic [TRI_W-1:0] td;
    rst        = 1'b1;
    tri_valid  = 1'b0;
    tri_data   = '0;
    bbox_valid = 1'b0;
    bbox_x_min = '0;
    bbox_x_max = '0;
    bbox_y_min = '0;
    bbox_y_max = '0;
    px_ready   = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // Reset values
    chk("rst_tri_ready", tri_ready, 1'b1);
    chk("rst_bbox_start", bbox_start, 1'b0);
    chk("rst_px_valid", px_valid, 1'b0);
    chk("rst_px_x", px_x, 8'd0);
    chk("rst_px_y", px_y, 8'd0);
    chk("rst_px_last", px_last, 1'b0);
    chk("rst_tri_done", tri_done, 1'b0);
    chk("rst_tri_err", tri_err, 1'b0);
    chk("rst_bbox_tri", bbox_tri, '0);

    // bbox_valid in IDLE is ignored
    bbox_valid = 1'b1;
    step();
    bbox_valid = 1'b0;
    chk("idle_bbox_ignored_ready", tri_ready, 1'b1);
    chk("idle_bbox_ignored_pxv", px_valid, 1'b0);

    // 3x2 box at full throughput
    td = {16'h3c00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600,
          16'h4700, 16'h4800, 16'h4880};
    send_tri(td);
    give_bbox(10, 12, 20, 21);
    chk("first_px_latency", px_valid, 1'b1);
    wait_done(c);
    chk("box6_cycles", c, 6);
    chk("bbox_tri_stable", bbox_tri, td);
    step();
    chk("box6_done_one_cycle", tri_done, 1'b0);
    chk("box6_ready_back", tri_ready, 1'b1);

    // Right/bottom screen edge, no wrap
    send_tri({9{16'hbeef}});
    give_bbox(255, 255, 254, 255);
    wait_done(c);
    chk("edge_cycles", c, 2);
    step();

    // Degenerate box
    send_tri({9{16'h1234}});
    give_bbox(40, 30, 0, 5);
    chk("degen_no_px", px_valid, 1'b0);
    chk("degen_done_now", tri_done, 1'b1);
    step();
    chk("degen_ready_2cyc", tri_ready, 1'b1);

    // Backpressure on the first beat
    send_tri({9{16'h0f0f}});
    px_ready = 1'b0;
    give_bbox(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold_valid", px_valid, 1'b1);
      chk("bp_hold_xy", {px_x, px_y, px_last}, 17'h0);
      if (i < 3) step();
    end
    px_ready = 1'b1;
    step();
    chk("bp_second_px", {px_valid, px_x, px_y, px_last}, {1'b1, 8'd1, 8'd0, 1'b1});
    wait_done(c);
    chk("bp_done_cycles", c, 1);
    step();

    // Reset mid-scan at pixel 3 of 6
    send_tri({9{16'h5555}});
    give_bbox(10, 12, 20, 21);
    step();
    step();
    chk("mid_px3", {px_x, px_y}, {8'd12, 8'd20});
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    exp_done = 0;
    chk("midrst_px_valid", px_valid, 1'b0);
    chk("midrst_tri_ready", tri_ready, 1'b1);
    chk("midrst_tri_done", tri_done, 1'b0);
    chk("midrst_bbox_tri", bbox_tri, '0);
    bbox_valid = 1'b1;
    bbox_x_min = 8'd1;
    bbox_x_max = 8'd2;
    bbox_y_min = 8'd1;
    bbox_y_max = 8'd2;
    step();
    bbox_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_bbox_ignored", {px_valid, tri_done, tri_ready}, 3'b001);
      step();
    end

    // Single-pixel box after recovery
    send_tri({9{16'haaaa}});
    give_bbox(5, 5, 7, 7);
    chk("single_px", {px_valid, px_x, px_y, px_last}, {1'b1, 8'd5, 8'd7, 1'b1});
    wait_done(c);
    chk("single_cycles", c, 1);
    step();

`ifdef RASTER_SCHED_WDT_EN
    // Watchdog abort
    send_tri({9{16'hdead}});
    exp_err++;
    c = 0;
    while (!tri_err && c < 200) begin
      chk("wdt_no_px", px_valid, 1'b0);
      step();
      c++;
    end
    chk("wdt_err_seen", tri_err, 1'b1);
    chk("wdt_cycles", c, 64);
    step();
    chk("wdt_ready_back", tri_ready, 1'b1);
    bbox_valid = 1'b1;
    step();
    bbox_valid = 1'b0;
    chk("wdt_late_bbox_ignored", {px_valid, tri_ready}, 2'b01);
    step();
`endif

    repeat (3) step();
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("done_all_seen", exp_done, 0);
    chk("err_all_seen", exp_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
